uart_echo_ctrl: RTL and testbench

//  Parametrised UART echo controller between uart_rx and uart_tx. Generates baud

---
 rtl/uart_echo_ctrl_pkg.sv | 22 ++
 rtl/uart_echo_ctrl_fifo.sv | 67 ++++++
 rtl/uart_echo_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_echo_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_ctrl_pkg.sv
// Shared encodings for the UART echo controller: transform modes and read-FSM states.
package uart_echo_ctrl_pkg;

  // Runtime transform selection, sampled when a word is written into the FIFO.
  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_ADD  = 2'b01,
    MODE_INV  = 2'b10,
    MODE_SWAP = 2'b11
  } mode_e;

  // Read side: request a frame, wait for uart_tx to take it, wait for it to finish.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  // Nibble swap is only defined for byte-wide words; other widths pass through.
  localparam int SWAP_W = 8;

endpackage

// File: rtl/uart_echo_ctrl_fifo.sv
// echo_fifo: synchronous FIFO with level-derived full/empty and distributed-RAM storage.
// Pointers wrap naturally; a push on a full FIFO is only taken if a pop happens in the
// same cycle, so callers may present push/pop unqualified.
module echo_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              wr_en, rd_en;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  // Head word is visible combinationally; no bypass from the write port.
  assign rd_data = mem[rd_ptr_q];

  // Qualify requests against occupancy and advance pointers / level.
  always_comb begin
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level state; contents are discarded on reset by zeroing the level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array: no reset so it maps onto LUT RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl: sits between uart_rx and uart_tx. Generates the shared baud enable,
// transforms each received word, queues it, and hands words to uart_tx one at a time
// over a level request/busy handshake. Also mirrors the last raw RX word on LEDs and
// flags words lost to a full queue.
module uart_echo_ctrl
  import uart_echo_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CK_DIV = 7,
  parameter int LED_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic                      ck_en,
  input  logic                      rx_rdy,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic [1:0]                mode,
  input  logic [DATA_W-1:0]         inc_val,
  output logic                      tx_en,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [LED_W-1:0]          led,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow,
  input  logic                      clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CK_DIV);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ck_en_q, ck_en_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              ovf_q, ovf_d;
  logic              tx_en_q, tx_en_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  state_e            state_q, state_d;

  logic [DATA_W-1:0] swap_w;
  logic [DATA_W-1:0] xf_data;
  logic [DATA_W-1:0] rd_data;
  logic [AW:0]       level;
  logic              full, empty;
  logic              pop;
  logic              drop;

  // Nibble swap only exists for byte words; wider/narrower words pass unchanged.
  generate
    if (DATA_W == SWAP_W) begin : g_swap
      assign swap_w = {rx_data[3:0], rx_data[7:4]};
    end else begin : g_noswap
      assign swap_w = rx_data;
    end
  endgenerate

  // Transform applied at write time so later mode changes never touch queued words.
  always_comb begin
    xf_data = rx_data;
    case (mode)
      MODE_ADD:  xf_data = rx_data + inc_val;
      MODE_INV:  xf_data = ~rx_data;
      MODE_SWAP: xf_data = swap_w;
      default:   xf_data = rx_data;
    endcase
  end

  echo_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_rdy),
    .wr_data (xf_data),
    .pop     (pop),
    .rd_data (rd_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // A word is lost only when full and the read side is not freeing a slot this cycle.
  assign drop = rx_rdy && full && !pop;

  // Baud divider, LED mirror and sticky overflow (set beats clear).
  always_comb begin
    ck_en_d = (cnt_q == CW'(CK_DIV - 1));
    cnt_d   = ck_en_d ? '0 : cnt_q + CW'(1);
    led_d   = rx_rdy ? rx_data[LED_W-1:0] : led_q;
    ovf_d   = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state: one word per request/busy/idle round trip.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!empty && !tx_busy) state_d = ST_REQ;
      ST_REQ:   if (tx_busy)            state_d = ST_DRAIN;
      ST_DRAIN: if (!tx_busy)           state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: pop the head into the TX holding register and raise the request;
  // drop the request once uart_tx reports busy.
  always_comb begin
    pop       = 1'b0;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          tx_en_d   = 1'b1;
          tx_data_d = rd_data;
        end
      end
      ST_REQ:   if (tx_busy) tx_en_d = 1'b0;
      ST_DRAIN: tx_en_d = 1'b0;
      default:  tx_en_d = 1'b0;
    endcase
  end

  // Datapath registers; reset abandons any in-flight request immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      ck_en_q   <= 1'b0;
      led_q     <= '0;
      ovf_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      ck_en_q   <= ck_en_d;
      led_q     <= led_d;
      ovf_q     <= ovf_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign ck_en      = ck_en_q;
  assign led        = led_q;
  assign overflow   = ovf_q;
  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Directed bench for uart_echo_ctrl with an expected-word scoreboard and a simple
// uart_tx model driven inline (busy raised on each accepted request).
module tb_uart_echo_ctrl;

  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int CK_DIV = 7;
  localparam int LED_W  = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ck_en;
  logic          rx_rdy = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] inc_val = '0;
  logic          tx_en;
  logic [DW-1:0] tx_data;
  logic          tx_busy = 1'b0;
  logic [LED_W-1:0] led;
  logic [4:0]    fifo_level;
  logic          overflow;
  logic          clr_ovf = 1'b0;

  int n_checks = 0;
  int n_err    = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  uart_echo_ctrl #(
    .DATA_W (DW), .DEPTH (DEPTH), .CK_DIV (CK_DIV), .LED_W (LED_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ck_en      (ck_en),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .mode       (mode),
    .inc_val    (inc_val),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .led        (led),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] xform(input logic [DW-1:0] d, input logic [1:0] m,
                                          input logic [DW-1:0] inc);
    case (m)
      2'b01:   return d + inc;
      2'b10:   return ~d;
      2'b11:   return {d[3:0], d[7:4]};
      default: return d;
    endcase
  endfunction

  // One rx_rdy strobe; the expected output is queued only if the word should survive.
  task automatic send(input logic [DW-1:0] d, input logic [1:0] m, input logic [DW-1:0] inc,
                      input bit kept);
    rx_data = d; mode = m; inc_val = inc; rx_rdy = 1'b1;
    if (kept) sb.push_back(xform(d, m, inc));
    @(posedge clk); #1;
    rx_rdy = 1'b0;
  endtask

  // Act as uart_tx for one frame: wait for the request, check the word, go busy, finish.
  task automatic serve(input string tag);
    logic [DW-1:0] exp;
    int t = 0;
    while (tx_en !== 1'b1 && t < 60) begin
      @(posedge clk); #1; t++;
    end
    chk({tag, "_req"}, tx_en, 1);
    if (tx_en !== 1'b1) return;
    chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    chk({tag, "_data"}, tx_data, exp);
    tx_busy = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_en_drop"}, tx_en, 0);
    repeat (2) @(posedge clk);
    #1 tx_busy = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ck_en", ck_en, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_led", led, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;

    // 1: baud enable every CK_DIV clocks, first one on the 7th edge after release
    for (int k = 1; k <= 3 * CK_DIV; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ck_en_%0d", k), ck_en, (k % CK_DIV) == 0);
    end

    // 2: add mode, latency, LED mirror, wraparound
    send(8'h41, 2'b01, 8'h01, 1);
    chk("lat_not_yet", tx_en, 0);
    chk("led_41", led, 8'h41);
    chk("lvl_1", fifo_level, 1);
    @(posedge clk); #1;
    chk("lat_n2", tx_en, 1);
    chk("lvl_0_after_pop", fifo_level, 0);
    serve("add_41");
    send(8'hFF, 2'b01, 8'h01, 1);
    serve("add_ff_wrap");

    // 3: invert and nibble swap; mode change after write leaves stored word alone
    send(8'h3C, 2'b10, 8'h00, 1);
    serve("inv_3c");
    send(8'h3C, 2'b11, 8'h00, 1);
    serve("swap_3c");
    tx_busy = 1'b1;
    send(8'h12, 2'b10, 8'h00, 1);
    mode = 2'b11;
    repeat (3) @(posedge clk);
    #1 tx_busy = 1'b0;
    serve("mode_chg_kept");

    // 4: fill, overflow on 17th, clear, set-beats-clear, drain in order
    tx_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) send(8'h10 + 8'(i), 2'b00, 8'h00, 1);
    chk("full_lvl", fifo_level, DEPTH);
    chk("full_no_ovf", overflow, 0);
    send(8'hEE, 2'b00, 8'h00, 0);
    chk("drop_lvl", fifo_level, DEPTH);
    chk("drop_ovf", overflow, 1);
    chk("drop_led", led, 8'hEE);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 0);
    clr_ovf = 1'b1;
    send(8'hDD, 2'b00, 8'h00, 0);
    clr_ovf = 1'b0;
    chk("set_beats_clr", overflow, 1);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    chk("clr_ovf2", overflow, 0);
    tx_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) serve($sformatf("drain_%0d", i));
    chk("drained_lvl", fifo_level, 0);

    // 5: push and pop on the same edge while full
    tx_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) send(8'h80 + 8'(i), 2'b00, 8'h00, 1);
    tx_busy = 1'b0;
    send(8'hA5, 2'b00, 8'h00, 1);
    chk("pp_lvl", fifo_level, DEPTH);
    chk("pp_no_ovf", overflow, 0);
    chk("pp_tx_en", tx_en, 1);
    for (int i = 0; i <= DEPTH; i++) serve($sformatf("pp_%0d", i));

    // 6: reset while a request is pending with words queued
    tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) send(8'h60 + 8'(i), 2'b00, 8'h00, 0);
    tx_busy = 1'b0;
    @(posedge clk); #1;
    chk("r6_req", tx_en, 1);
    chk("r6_lvl", fifo_level, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("r6_tx_en_async", tx_en, 0);
    chk("r6_lvl_async", fifo_level, 0);
    chk("r6_led_async", led, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk($sformatf("r6_no_stale_%0d", k), tx_en, 0);
    end
    send(8'h5A, 2'b00, 8'h00, 1);
    serve("r6_after");
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
